// File: rtl/mem_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mem_arb_pkg
// Purpose  : Shared types and default sizing for the memory port arbiter.
//            Holds the FSM state encoding, the grant-side encoding and the
//            default address/data width and ack timeout.
// Revision : 1.0 - initial release
// ============================================================================
package mem_arb_pkg;

   localparam int DEFAULT_ADDR_W  = 32;
   localparam int DEFAULT_DATA_W  = 32;
   localparam int DEFAULT_TIMEOUT = 255;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      SERVE_I = 2'd1,
      SERVE_D = 2'd2
   } state_t;

   typedef enum logic {
      GRANT_I = 1'b0,
      GRANT_D = 1'b1
   } grant_t;

endpackage : mem_arb_pkg
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_port_arbiter
// Purpose  : Shares one single-outstanding memory port between the
//            instruction-fetch and data stages of a pipeline. Alternates the
//            grant on contention, latches the granted request, returns read
//            data with a one-cycle valid pulse, and aborts a transaction with
//            a sticky error if the memory never acknowledges.
// Ports    : clk, rst            - clock, synchronous active-high reset
//            if_req_i/if_addr_i  - fetch read request
//            if_rdata_o/if_valid_o - fetch result + completion pulse
//            d_req_i/d_we_i/d_addr_i/d_wdata_i/d_be_i - data-stage request
//            d_rdata_o/d_valid_o - data read result + completion pulse
//            mem_req_o/mem_we_o/mem_addr_o/mem_wdata_o/mem_be_o - memory port
//            mem_ack_i/mem_rdata_i - memory completion and read data
//            stall_o             - pipeline freeze while a request is pending
//            err_o               - sticky ack-timeout flag
// Revision : 1.0 - initial release
// ============================================================================
module mem_port_arbiter
   import mem_arb_pkg::*;
#(
   parameter int ADDR_W  = DEFAULT_ADDR_W,
   parameter int DATA_W  = DEFAULT_DATA_W,
   parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              if_req_i,
   input  logic [ADDR_W-1:0] if_addr_i,
   output logic [DATA_W-1:0] if_rdata_o,
   output logic              if_valid_o,
   input  logic              d_req_i,
   input  logic              d_we_i,
   input  logic [ADDR_W-1:0] d_addr_i,
   input  logic [DATA_W-1:0] d_wdata_i,
   input  logic [3:0]        d_be_i,
   output logic [DATA_W-1:0] d_rdata_o,
   output logic              d_valid_o,
   output logic              mem_req_o,
   output logic              mem_we_o,
   output logic [ADDR_W-1:0] mem_addr_o,
   output logic [DATA_W-1:0] mem_wdata_o,
   output logic [3:0]        mem_be_o,
   input  logic              mem_ack_i,
   input  logic [DATA_W-1:0] mem_rdata_i,
   output logic              stall_o,
   output logic              err_o
);

   // Counter must hold TIMEOUT-1 and be at least 8 bits wide.
   localparam int CNT_W = ($clog2(TIMEOUT) > 8) ? $clog2(TIMEOUT) : 8;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

   state_t              state_q, state_d;
   // Side favoured on the next tie. Reset to D so the data stage wins the
   // first contention; afterwards it always points at the side not just
   // granted, which yields strict alternation under contention.
   grant_t              last_grant_q, last_grant_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [DATA_W-1:0]   wdata_q, wdata_d;
   logic                we_q, we_d;
   logic [3:0]          be_q, be_d;
   logic [DATA_W-1:0]   if_rdata_q, if_rdata_d;
   logic [DATA_W-1:0]   d_rdata_q, d_rdata_d;
   logic                if_valid_q, if_valid_d;
   logic                d_valid_q, d_valid_d;
   logic                err_q, err_d;

   logic                timeout_hit;

   assign timeout_hit = (cnt_q == CNT_LAST);

   always_comb begin
      state_d      = state_q;
      last_grant_d = last_grant_q;
      cnt_d        = cnt_q;
      addr_d       = addr_q;
      wdata_d      = wdata_q;
      we_d         = we_q;
      be_d         = be_q;
      if_rdata_d   = if_rdata_q;
      d_rdata_d    = d_rdata_q;
      if_valid_d   = 1'b0;
      d_valid_d    = 1'b0;
      err_d        = err_q;

      case (state_q)
         IDLE: begin
            // Hold off while a valid pulse is out so the requester can drop
            // its request before it is granted again. mem_ack_i is ignored.
            if (!(if_valid_q || d_valid_q)) begin
               if (d_req_i && (!if_req_i || last_grant_q == GRANT_D)) begin
                  state_d      = SERVE_D;
                  last_grant_d = GRANT_I;
                  cnt_d        = '0;
                  addr_d       = d_addr_i;
                  wdata_d      = d_wdata_i;
                  we_d         = d_we_i;
                  be_d         = d_be_i;
               end else if (if_req_i) begin
                  state_d      = SERVE_I;
                  last_grant_d = GRANT_D;
                  cnt_d        = '0;
                  addr_d       = if_addr_i;
                  we_d         = 1'b0;
                  be_d         = 4'hF;
               end
            end
         end
         SERVE_I: begin
            if (mem_ack_i) begin
               if_rdata_d = mem_rdata_i;
               if_valid_d = 1'b1;
               state_d    = IDLE;
            end else if (timeout_hit) begin
               err_d      = 1'b1;
               if_valid_d = 1'b1;
               state_d    = IDLE;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         SERVE_D: begin
            if (mem_ack_i) begin
               if (!we_q) begin
                  d_rdata_d = mem_rdata_i;
               end
               d_valid_d = 1'b1;
               state_d   = IDLE;
            end else if (timeout_hit) begin
               err_d     = 1'b1;
               d_valid_d = 1'b1;
               state_d   = IDLE;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         last_grant_q <= GRANT_D;
         cnt_q        <= '0;
         addr_q       <= '0;
         wdata_q      <= '0;
         we_q         <= 1'b0;
         be_q         <= 4'h0;
         if_rdata_q   <= '0;
         d_rdata_q    <= '0;
         if_valid_q   <= 1'b0;
         d_valid_q    <= 1'b0;
         err_q        <= 1'b0;
      end else begin
         state_q      <= state_d;
         last_grant_q <= last_grant_d;
         cnt_q        <= cnt_d;
         addr_q       <= addr_d;
         wdata_q      <= wdata_d;
         we_q         <= we_d;
         be_q         <= be_d;
         if_rdata_q   <= if_rdata_d;
         d_rdata_q    <= d_rdata_d;
         if_valid_q   <= if_valid_d;
         d_valid_q    <= d_valid_d;
         err_q        <= err_d;
      end
   end

   assign mem_req_o   = (state_q == SERVE_I) || (state_q == SERVE_D);
   assign mem_we_o    = we_q;
   assign mem_addr_o  = addr_q;
   assign mem_wdata_o = wdata_q;
   assign mem_be_o    = be_q;

   assign if_rdata_o  = if_rdata_q;
   assign if_valid_o  = if_valid_q;
   assign d_rdata_o   = d_rdata_q;
   assign d_valid_o   = d_valid_q;
   assign err_o       = err_q;

   assign stall_o = (if_req_i && !if_valid_q) || (d_req_i && !d_valid_q);

endmodule : mem_port_arbiter
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_port_arbiter
// Purpose  : Self-checking bench for mem_port_arbiter (TIMEOUT set to 4).
//            Directed scenarios plus a randomized run against a
//            transaction-level reference model of the arbitration rules.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_port_arbiter;

   localparam int ADDR_W  = 32;
   localparam int DATA_W  = 32;
   localparam int TIMEOUT = 4;

   logic              clk = 1'b0;
   logic              rst;
   logic              if_req_i;
   logic [ADDR_W-1:0] if_addr_i;
   logic [DATA_W-1:0] if_rdata_o;
   logic              if_valid_o;
   logic              d_req_i;
   logic              d_we_i;
   logic [ADDR_W-1:0] d_addr_i;
   logic [DATA_W-1:0] d_wdata_i;
   logic [3:0]        d_be_i;
   logic [DATA_W-1:0] d_rdata_o;
   logic              d_valid_o;
   logic              mem_req_o;
   logic              mem_we_o;
   logic [ADDR_W-1:0] mem_addr_o;
   logic [DATA_W-1:0] mem_wdata_o;
   logic [3:0]        mem_be_o;
   logic              mem_ack_i;
   logic [DATA_W-1:0] mem_rdata_i;
   logic              stall_o;
   logic              err_o;

   int checks = 0;
   int errors = 0;

   // Reference-model view of the read-data registers and tie state.
   logic [DATA_W-1:0] m_if_rdata;
   logic [DATA_W-1:0] m_d_rdata;
   bit                m_d_wins_tie;

   mem_port_arbiter #(
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W),
      .TIMEOUT(TIMEOUT)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .if_req_i   (if_req_i),
      .if_addr_i  (if_addr_i),
      .if_rdata_o (if_rdata_o),
      .if_valid_o (if_valid_o),
      .d_req_i    (d_req_i),
      .d_we_i     (d_we_i),
      .d_addr_i   (d_addr_i),
      .d_wdata_i  (d_wdata_i),
      .d_be_i     (d_be_i),
      .d_rdata_o  (d_rdata_o),
      .d_valid_o  (d_valid_o),
      .mem_req_o  (mem_req_o),
      .mem_we_o   (mem_we_o),
      .mem_addr_o (mem_addr_o),
      .mem_wdata_o(mem_wdata_o),
      .mem_be_o   (mem_be_o),
      .mem_ack_i  (mem_ack_i),
      .mem_rdata_i(mem_rdata_i),
      .stall_o    (stall_o),
      .err_o      (err_o)
   );

   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1);
   end

   // Advance one clock; outputs are sampled and inputs driven 1ns after the edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      if_req_i = 1'b0; if_addr_i = '0;
      d_req_i = 1'b0; d_we_i = 1'b0; d_addr_i = '0; d_wdata_i = '0; d_be_i = 4'h0;
      mem_ack_i = 1'b1; mem_rdata_i = 32'hFFFF_FFFF;
      tick(); tick();
      checks++; if (mem_req_o !== 1'b0 || mem_we_o !== 1'b0 || mem_be_o !== 4'h0) begin
         errors++; $display("FAIL reset_mem_ctl: got req=%b we=%b be=%h expected 0 0 0", mem_req_o, mem_we_o, mem_be_o); end
      checks++; if (mem_addr_o !== '0 || mem_wdata_o !== '0) begin
         errors++; $display("FAIL reset_mem_data: got addr=%h wdata=%h expected 0 0", mem_addr_o, mem_wdata_o); end
      checks++; if (if_rdata_o !== '0 || d_rdata_o !== '0) begin
         errors++; $display("FAIL reset_rdata: got if=%h d=%h expected 0 0", if_rdata_o, d_rdata_o); end
      checks++; if (if_valid_o !== 1'b0 || d_valid_o !== 1'b0 || err_o !== 1'b0 || stall_o !== 1'b0) begin
         errors++; $display("FAIL reset_flags: got ifv=%b dv=%b err=%b stall=%b expected 0", if_valid_o, d_valid_o, err_o, stall_o); end
      rst = 1'b0; mem_ack_i = 1'b0; mem_rdata_i = '0;
      m_if_rdata = '0; m_d_rdata = '0; m_d_wins_tie = 1'b1;
      // Acks while idle must be ignored.
      tick();
      checks++; if (mem_req_o !== 1'b0 || if_valid_o !== 1'b0 || d_valid_o !== 1'b0) begin
         errors++; $display("FAIL idle_ack_ignored: got req=%b ifv=%b dv=%b expected 0", mem_req_o, if_valid_o, d_valid_o); end
   endtask

   task automatic test_single_fetch();
      if_req_i = 1'b1; if_addr_i = 32'h0000_0100;
      tick();
      checks++; if (mem_req_o !== 1'b1 || mem_addr_o !== 32'h100 || mem_we_o !== 1'b0 || mem_be_o !== 4'hF) begin
         errors++; $display("FAIL fetch_issue: got req=%b addr=%h we=%b be=%h expected 1 100 0 f", mem_req_o, mem_addr_o, mem_we_o, mem_be_o); end
      checks++; if (stall_o !== 1'b1) begin
         errors++; $display("FAIL fetch_stall: got %b expected 1", stall_o); end
      mem_ack_i = 1'b1; mem_rdata_i = 32'hDEAD_BEEF;
      tick();
      m_if_rdata = 32'hDEAD_BEEF; m_d_wins_tie = 1'b1;
      checks++; if (if_valid_o !== 1'b1 || d_valid_o !== 1'b0 || if_rdata_o !== 32'hDEAD_BEEF) begin
         errors++; $display("FAIL fetch_result: got ifv=%b dv=%b rdata=%h expected 1 0 deadbeef", if_valid_o, d_valid_o, if_rdata_o); end
      checks++; if (mem_req_o !== 1'b0 || stall_o !== 1'b0) begin
         errors++; $display("FAIL fetch_done: got req=%b stall=%b expected 0 0", mem_req_o, stall_o); end
      mem_ack_i = 1'b0; if_req_i = 1'b0;
      tick();
      checks++; if (if_valid_o !== 1'b0 || mem_req_o !== 1'b0) begin
         errors++; $display("FAIL fetch_pulse_width: got ifv=%b req=%b expected 0 0", if_valid_o, mem_req_o); end
   endtask

   task automatic test_both_requests();
      rst = 1'b1; tick(); rst = 1'b0;
      m_if_rdata = '0; m_d_rdata = '0;
      if_req_i = 1'b1; if_addr_i = 32'h0000_3000;
      d_req_i = 1'b1; d_we_i = 1'b0; d_addr_i = 32'h0000_2000; d_be_i = 4'hF;
      tick();
      checks++; if (mem_req_o !== 1'b1 || mem_addr_o !== 32'h2000 || mem_we_o !== 1'b0 || stall_o !== 1'b1) begin
         errors++; $display("FAIL both_d_first: got req=%b addr=%h we=%b stall=%b expected 1 2000 0 1", mem_req_o, mem_addr_o, mem_we_o, stall_o); end
      mem_ack_i = 1'b1; mem_rdata_i = 32'h1111_1111;
      tick();
      m_d_rdata = 32'h1111_1111;
      checks++; if (d_valid_o !== 1'b1 || if_valid_o !== 1'b0 || d_rdata_o !== m_d_rdata || stall_o !== 1'b1) begin
         errors++; $display("FAIL both_d_done: got dv=%b ifv=%b rdata=%h stall=%b expected 1 0 %h 1", d_valid_o, if_valid_o, d_rdata_o, stall_o, m_d_rdata); end
      mem_ack_i = 1'b0; d_req_i = 1'b0;
      tick();
      checks++; if (mem_req_o !== 1'b0 || stall_o !== 1'b1) begin
         errors++; $display("FAIL both_gap: got req=%b stall=%b expected 0 1", mem_req_o, stall_o); end
      tick();
      checks++; if (mem_req_o !== 1'b1 || mem_addr_o !== 32'h3000 || mem_be_o !== 4'hF) begin
         errors++; $display("FAIL both_i_second: got req=%b addr=%h be=%h expected 1 3000 f", mem_req_o, mem_addr_o, mem_be_o); end
      mem_ack_i = 1'b1; mem_rdata_i = 32'h2222_2222;
      tick();
      m_if_rdata = 32'h2222_2222; m_d_wins_tie = 1'b1;
      checks++; if (if_valid_o !== 1'b1 || if_rdata_o !== m_if_rdata || stall_o !== 1'b0 || d_rdata_o !== m_d_rdata) begin
         errors++; $display("FAIL both_i_done: got ifv=%b rdata=%h stall=%b drdata=%h expected 1 %h 0 %h", if_valid_o, if_rdata_o, stall_o, d_rdata_o, m_if_rdata, m_d_rdata); end
      mem_ack_i = 1'b0; if_req_i = 1'b0;
      tick();
   endtask

   task automatic test_write();
      d_req_i = 1'b1; d_we_i = 1'b1; d_be_i = 4'b0011; d_wdata_i = 32'h0000_1234; d_addr_i = 32'h0000_0040;
      tick();
      checks++; if (mem_req_o !== 1'b1 || mem_we_o !== 1'b1 || mem_be_o !== 4'b0011 || mem_wdata_o !== 32'h1234 || mem_addr_o !== 32'h40) begin
         errors++; $display("FAIL write_issue: got req=%b we=%b be=%b wdata=%h addr=%h expected 1 1 0011 1234 40", mem_req_o, mem_we_o, mem_be_o, mem_wdata_o, mem_addr_o); end
      mem_ack_i = 1'b1; mem_rdata_i = 32'hBAD0_BAD0;
      tick();
      m_d_wins_tie = 1'b0;
      checks++; if (d_valid_o !== 1'b1 || d_rdata_o !== m_d_rdata) begin
         errors++; $display("FAIL write_done: got dv=%b rdata=%h expected 1 %h", d_valid_o, d_rdata_o, m_d_rdata); end
      mem_ack_i = 1'b0; d_req_i = 1'b0; d_we_i = 1'b0;
      tick(); tick();
   endtask

   task automatic test_random();
      bit                p_mem_req = 1'b0, p_ack = 1'b0, p_valid = 1'b0;
      bit                p_if_req = 1'b0, p_d_req = 1'b0;
      bit                s_is_d = 1'b0, s_we = 1'b0;
      bit                exp_req, exp_ifv, exp_dv, exp_stall, side_d;
      logic [DATA_W-1:0] p_rdata = '0;
      int                wait_cnt = 0;
      for (int cyc = 0; cyc < 700; cyc++) begin
         tick();
         // Rules: a served transaction ends on ack; an idle arbiter grants any
         // pending request unless a completion pulse is currently out.
         exp_req = p_mem_req ? !p_ack : ((p_if_req || p_d_req) && !p_valid);
         exp_ifv = p_mem_req && p_ack && !s_is_d;
         exp_dv  = p_mem_req && p_ack && s_is_d;
         if (exp_ifv) m_if_rdata = p_rdata;
         if (exp_dv && !s_we) m_d_rdata = p_rdata;
         checks++; if (mem_req_o !== exp_req || if_valid_o !== exp_ifv || d_valid_o !== exp_dv) begin
            errors++; $display("FAIL rand_ctl cyc=%0d: got req=%b ifv=%b dv=%b expected %b %b %b", cyc, mem_req_o, if_valid_o, d_valid_o, exp_req, exp_ifv, exp_dv); end
         checks++; if (if_rdata_o !== m_if_rdata || d_rdata_o !== m_d_rdata || err_o !== 1'b0) begin
            errors++; $display("FAIL rand_data cyc=%0d: got if=%h d=%h err=%b expected %h %h 0", cyc, if_rdata_o, d_rdata_o, err_o, m_if_rdata, m_d_rdata); end
         if (exp_req && !p_mem_req) begin
            side_d = (p_if_req && p_d_req) ? m_d_wins_tie : p_d_req;
            m_d_wins_tie = !side_d;
            s_is_d = side_d;
            s_we = side_d ? d_we_i : 1'b0;
            checks++;
            if (side_d ? (mem_addr_o !== d_addr_i || mem_we_o !== d_we_i || mem_be_o !== d_be_i ||
                          (d_we_i && mem_wdata_o !== d_wdata_i))
                       : (mem_addr_o !== if_addr_i || mem_we_o !== 1'b0 || mem_be_o !== 4'hF)) begin
               errors++; $display("FAIL rand_grant cyc=%0d side_d=%b: got addr=%h we=%b be=%h wdata=%h", cyc, side_d, mem_addr_o, mem_we_o, mem_be_o, mem_wdata_o); end
            wait_cnt = $urandom_range(0, 2);
         end
         exp_stall = (if_req_i && !exp_ifv) || (d_req_i && !exp_dv);
         checks++; if (stall_o !== exp_stall) begin
            errors++; $display("FAIL rand_stall cyc=%0d: got %b expected %b", cyc, stall_o, exp_stall); end

         // Drive next cycle: memory responder (random noise while idle).
         p_mem_req = exp_req;
         p_valid = exp_ifv || exp_dv;
         mem_rdata_i = $urandom;
         if (exp_req) begin
            if (wait_cnt == 0) mem_ack_i = 1'b1;
            else begin mem_ack_i = 1'b0; wait_cnt--; end
         end else begin
            mem_ack_i = (cyc < 660) ? 1'($urandom_range(0, 1)) : 1'b0;
         end
         p_ack = mem_ack_i;
         p_rdata = mem_rdata_i;
         // Requesters: drop on completion, occasionally withdraw while served.
         if (exp_ifv) if_req_i = 1'b0;
         if (exp_dv) d_req_i = 1'b0;
         if (exp_req && !s_is_d && $urandom_range(0, 7) == 0) if_req_i = 1'b0;
         if (exp_req && s_is_d && $urandom_range(0, 7) == 0) d_req_i = 1'b0;
         if (cyc < 660 && !if_req_i && $urandom_range(0, 2) == 0) begin
            if_req_i = 1'b1; if_addr_i = $urandom;
         end
         if (cyc < 660 && !d_req_i && $urandom_range(0, 2) == 0) begin
            d_req_i = 1'b1; d_we_i = 1'($urandom_range(0, 1)); d_addr_i = $urandom;
            d_wdata_i = $urandom; d_be_i = 4'($urandom_range(0, 15));
         end
         p_if_req = if_req_i;
         p_d_req = d_req_i;
      end
      mem_ack_i = 1'b0; if_req_i = 1'b0; d_req_i = 1'b0; d_we_i = 1'b0;
      tick(); tick(); tick();
   endtask

   task automatic test_timeout();
      d_req_i = 1'b1; d_we_i = 1'b0; d_addr_i = 32'h0000_0ABC; mem_ack_i = 1'b0;
      tick();
      for (int i = 0; i < TIMEOUT; i++) begin
         checks++; if (mem_req_o !== 1'b1 || err_o !== 1'b0 || d_valid_o !== 1'b0) begin
            errors++; $display("FAIL timeout_wait cyc=%0d: got req=%b err=%b dv=%b expected 1 0 0", i, mem_req_o, err_o, d_valid_o); end
         tick();
      end
      checks++; if (err_o !== 1'b1 || d_valid_o !== 1'b1 || mem_req_o !== 1'b0 || d_rdata_o !== m_d_rdata) begin
         errors++; $display("FAIL timeout_hit: got err=%b dv=%b req=%b rdata=%h expected 1 1 0 %h", err_o, d_valid_o, mem_req_o, d_rdata_o, m_d_rdata); end
      d_req_i = 1'b0;
      mem_ack_i = 1'b1; mem_rdata_i = 32'h5555_AAAA;
      tick(); tick();
      checks++; if (err_o !== 1'b1 || d_valid_o !== 1'b0 || if_valid_o !== 1'b0 || mem_req_o !== 1'b0) begin
         errors++; $display("FAIL timeout_sticky: got err=%b dv=%b ifv=%b req=%b expected 1 0 0 0", err_o, d_valid_o, if_valid_o, mem_req_o); end
      mem_ack_i = 1'b0;
   endtask

   task automatic test_reset_mid();
      d_req_i = 1'b1; d_we_i = 1'b0; d_addr_i = 32'h0000_0777;
      tick();
      checks++; if (mem_req_o !== 1'b1 || mem_addr_o !== 32'h777) begin
         errors++; $display("FAIL midrst_serve: got req=%b addr=%h expected 1 777", mem_req_o, mem_addr_o); end
      rst = 1'b1;
      tick();
      checks++; if (mem_req_o !== 1'b0 || d_valid_o !== 1'b0 || err_o !== 1'b0 || d_rdata_o !== '0) begin
         errors++; $display("FAIL midrst_abort: got req=%b dv=%b err=%b rdata=%h expected 0 0 0 0", mem_req_o, d_valid_o, err_o, d_rdata_o); end
      rst = 1'b0; d_req_i = 1'b0; mem_ack_i = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         checks++; if (mem_req_o !== 1'b0 || d_valid_o !== 1'b0 || if_valid_o !== 1'b0) begin
            errors++; $display("FAIL midrst_idle cyc=%0d: got req=%b dv=%b ifv=%b expected 0 0 0", i, mem_req_o, d_valid_o, if_valid_o); end
      end
      mem_ack_i = 1'b0;
   endtask

   initial begin
      test_reset();
      test_single_fetch();
      test_both_requests();
      test_write();
      test_random();
      test_timeout();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule : tb_mem_port_arbiter
`default_nettype wire

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, the address width.
REQ-002 SHALL have parameter DATA_W, default 32, the data width.
REQ-003 SHALL have parameter TIMEOUT, default 255, the maximum cycles to wait for mem_ack_i.
REQ-004 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-006 SHALL have ports if_req_i  input  1, if_addr_i  input  ADDR_W  instruction-fetch read request and address.
REQ-007 SHALL have ports if_rdata_o  output  DATA_W, if_valid_o  output  1  fetch result and one-cycle completion pulse.
REQ-008 SHALL have ports d_req_i  input  1, d_we_i  input  1, d_addr_i  input  ADDR_W, d_wdata_i  input  DATA_W, d_be_i  input  4  data-stage request.
REQ-009 SHALL have ports d_rdata_o  output  DATA_W, d_valid_o  output  1  data read result and one-cycle completion pulse (reads and writes).
REQ-010 SHALL have ports mem_req_o  output  1, mem_we_o  output  1, mem_addr_o  output  ADDR_W, mem_wdata_o  output  DATA_W, mem_be_o  output  4  shared memory port.
REQ-011 SHALL have ports mem_ack_i  input  1, mem_rdata_i  input  DATA_W  memory completion and read data.
REQ-012 SHALL have ports stall_o  output  1, err_o  output  1  pipeline freeze and sticky timeout flag.

Function
REQ-013 SHALL implement FSM states IDLE, SERVE_I, SERVE_D.
REQ-014 SHALL, in IDLE with only d_req_i high, move to SERVE_D; with only if_req_i high, move to SERVE_I; with neither, stay in IDLE.
REQ-015 SHALL, in IDLE with both requests high, grant the side not granted last (last_grant register, D after reset).
REQ-016 SHALL latch the address, write data, we and be of the granted requester at the grant edge; mem_* outputs SHALL be driven from these registers only.
REQ-017 SHALL assert mem_req_o exactly while in SERVE_I or SERVE_D, with mem_we_o forced to 0 and mem_be_o to 4'hF in SERVE_I.
REQ-018 SHALL, on mem_ack_i high in SERVE_x, capture mem_rdata_i into x_rdata_o (reads only), pulse x_valid_o high for the following cycle, and return to IDLE.
REQ-019 SHALL leave d_rdata_o unchanged on a completed write.
REQ-020 SHALL give minimum latency of 2 cycles: request seen at edge N, mem_req_o high in cycle N+1, ack in N+1, valid in N+2.
REQ-021 SHALL ignore mem_ack_i while in IDLE.
REQ-022 SHALL NOT grant a new request in the cycle a valid pulse is high, so a requester can drop its request after valid without being re-served.
REQ-023 SHALL drive stall_o = (if_req_i AND NOT if_valid_o) OR (d_req_i AND NOT d_valid_o), combinationally.
REQ-024 SHALL complete a granted transaction even if the requester withdraws; the valid pulse SHALL still be issued.
REQ-025 SHALL count cycles in SERVE_x with an 8-bit-or-wider counter cleared on grant; on reaching TIMEOUT without ack, SHALL set err_o, pulse x_valid_o with rdata unchanged, and return to IDLE.
REQ-026 SHALL keep err_o set until reset.

Reset
REQ-027 SHALL, on rst high at a clock edge, enter IDLE, set last_grant to D, and clear the timeout counter.
REQ-028 SHALL, on rst high at a clock edge, clear mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_be_o, if_rdata_o, d_rdata_o, if_valid_o, d_valid_o and err_o to 0.
REQ-029 SHALL abandon any in-flight transaction on reset mid-operation, with no valid pulse, and drop mem_req_o in the cycle after the reset edge.

Structure
REQ-030 SHALL take the state enum and the default ADDR_W, DATA_W and TIMEOUT constants from a shared package, mem_arb_pkg.
REQ-031 SHALL be a single module with no sub-module; the timeout counter is inline.

Verification
REQ-032 SHALL cover: if_req_i=1, if_addr_i=0x100, ack after 0 wait cycles with rdata=0xDEADBEEF -> if_valid_o one cycle later, if_rdata_o=0xDEADBEEF, latency 2.
REQ-033 SHALL cover: both requests high from reset -> D served first, then I; mem_addr_o shows d_addr_i then if_addr_i; stall_o high until both valids.
REQ-034 SHALL cover: d_we_i=1, d_be_i=4'b0011, d_wdata_i=0x1234 -> mem_we_o=1, mem_be_o=0011, d_valid_o pulses, d_rdata_o unchanged.
REQ-035 SHALL cover: ack withheld for TIMEOUT=4 (override) -> err_o=1 after 4 cycles in SERVE, valid pulse, FSM in IDLE, err_o held.
REQ-036 SHALL cover: rst asserted 1 cycle into SERVE_D -> mem_req_o=0 next cycle, no d_valid_o, state IDLE.
